// File: rtl/hart_mailbox.sv
`default_nettype none
// ============================================================================
// Module : hart_mailbox
// Inter-hart message mailbox: one receive FIFO per hart, any hart may push.
// Revision: 1.0 - initial release
// ============================================================================
module hart_mailbox #(
  parameter int NCORES     = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int CNTW       = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NCORES-1:0]      sel_packed_i,
  input  logic [NCORES-1:0]      we_packed_i,
  input  logic [4*NCORES-1:0]    addr_packed_i,
  input  logic [32*NCORES-1:0]   wdata_packed_i,
  output logic [32*NCORES-1:0]   rdata_packed_o,
  output logic [NCORES-1:0]      stall_packed_o
);

  localparam int DW = (NCORES > 1) ? $clog2(NCORES) : 1;
  localparam int PW = $clog2(FIFO_DEPTH);

  localparam logic [1:0]      c_OFF_DEST   = 2'd0;
  localparam logic [1:0]      c_OFF_TX     = 2'd1;
  localparam logic [1:0]      c_OFF_RX     = 2'd2;
  localparam logic [1:0]      c_OFF_STATUS = 2'd3;
  localparam logic [CNTW-1:0] c_FULL       = CNTW'(FIFO_DEPTH);

  logic [DW-1:0]   r_dest  [NCORES];
  logic [31:0]     r_mem   [NCORES][FIFO_DEPTH];
  logic [PW-1:0]   r_wptr  [NCORES];
  logic [PW-1:0]   r_rptr  [NCORES];
  logic [CNTW-1:0] r_cnt   [NCORES];
  logic [DW-1:0]   r_rr    [NCORES];
  logic [31:0]     r_rdata [NCORES];

  logic [1:0]        w_off   [NCORES];
  logic [NCORES-1:0] w_rd;
  logic [NCORES-1:0] w_tx;
  logic [NCORES-1:0] w_pop;
  logic [NCORES-1:0] w_dest_we;
  logic [NCORES-1:0] w_push;
  logic [NCORES-1:0] w_granted;
  logic [DW-1:0]     w_win   [NCORES];
  logic [31:0]       w_pdata [NCORES];
  logic [31:0]       w_rval  [NCORES];

  function automatic logic [DW-1:0] rr_idx(input logic [DW-1:0] base, input int step);
    return DW'((int'(base) + step) % NCORES);
  endfunction

  always_comb begin
    for (int k = 0; k < NCORES; k++) begin
      w_off[k]     = addr_packed_i[4*k+2 +: 2];
      w_rd[k]      = sel_packed_i[k] & ~we_packed_i[k];
      w_dest_we[k] = sel_packed_i[k] & we_packed_i[k] & (w_off[k] == c_OFF_DEST);
      // Out-of-range destinations are dropped here so they complete unstalled.
      w_tx[k]      = sel_packed_i[k] & we_packed_i[k] & (w_off[k] == c_OFF_TX) &
                     (32'(r_dest[k]) < 32'(NCORES));
      w_pop[k]     = w_rd[k] & (w_off[k] == c_OFF_RX) & (r_cnt[k] != '0);
    end
  end

  // Per-destination round-robin; a full FIFO grants nobody, even if popped now.
  always_comb begin
    w_push    = '0;
    w_granted = '0;
    for (int d = 0; d < NCORES; d++) begin
      w_win[d] = '0;
      if (r_cnt[d] != c_FULL) begin
        for (int i = 0; i < NCORES; i++) begin
          if (!w_push[d] && w_tx[rr_idx(r_rr[d], i)] &&
              (r_dest[rr_idx(r_rr[d], i)] == DW'(d))) begin
            w_push[d]                       = 1'b1;
            w_win[d]                        = rr_idx(r_rr[d], i);
            w_granted[rr_idx(r_rr[d], i)]   = 1'b1;
          end
        end
      end
      w_pdata[d] = wdata_packed_i[32*w_win[d] +: 32];
    end
  end

  assign stall_packed_o = w_tx & ~w_granted;

  always_comb begin
    for (int k = 0; k < NCORES; k++) begin
      w_rval[k] = '0;
      case (w_off[k])
        c_OFF_DEST:   w_rval[k] = 32'(r_dest[k]);
        c_OFF_RX:     if (w_pop[k]) w_rval[k] = r_mem[k][r_rptr[k]];
        c_OFF_STATUS: w_rval[k] = {16'b0, 8'(r_cnt[k]), 6'b0,
                                   (r_cnt[k] == c_FULL), (r_cnt[k] == '0)};
        default:      w_rval[k] = '0;
      endcase
      rdata_packed_o[32*k +: 32] = r_rdata[k];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < NCORES; k++) begin
        r_dest[k]  <= '0;
        r_rdata[k] <= '0;
        r_wptr[k]  <= '0;
        r_rptr[k]  <= '0;
        r_cnt[k]   <= '0;
        r_rr[k]    <= '0;
      end
    end else begin
      for (int k = 0; k < NCORES; k++) begin
        if (w_dest_we[k]) r_dest[k]  <= wdata_packed_i[32*k +: DW];
        if (w_rd[k])      r_rdata[k] <= w_rval[k];
        if (w_push[k]) begin
          r_wptr[k] <= r_wptr[k] + 1'b1;
          r_rr[k]   <= rr_idx(w_win[k], 1);
        end
        if (w_pop[k]) r_rptr[k] <= r_rptr[k] + 1'b1;
        case ({w_push[k], w_pop[k]})
          2'b10:   r_cnt[k] <= r_cnt[k] + 1'b1;
          2'b01:   r_cnt[k] <= r_cnt[k] - 1'b1;
          default: r_cnt[k] <= r_cnt[k];
        endcase
      end
    end
  end

  always_ff @(posedge clk_i) begin
    for (int d = 0; d < NCORES; d++) begin
      if (w_push[d]) r_mem[d][r_wptr[d]] <= w_pdata[d];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hart_mailbox.sv
`default_nettype none
// ============================================================================
// Module : tb_hart_mailbox
// Directed and randomized checks of hart_mailbox against a queue-based model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_hart_mailbox;
  localparam int NC    = 4;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_ni;
  logic              sel   [NC];
  logic              we    [NC];
  logic [3:0]        addr  [NC];
  logic [31:0]       wdata [NC];
  logic [NC-1:0]     sel_p, we_p;
  logic [4*NC-1:0]   addr_p;
  logic [32*NC-1:0]  wdata_p;
  logic [32*NC-1:0]  rdata_packed_o;
  logic [NC-1:0]     stall_packed_o;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0]   mq [NC][$];
  int            m_dest [NC];
  int            m_rr   [NC];
  logic [31:0]   m_exp_rd [NC];
  logic [NC-1:0] exp_stall;
  logic [NC-1:0] dut_st;

  always #5 clk = ~clk;

  always_comb begin
    for (int k = 0; k < NC; k++) begin
      sel_p[k]            = sel[k];
      we_p[k]             = we[k];
      addr_p[4*k +: 4]    = addr[k];
      wdata_p[32*k +: 32] = wdata[k];
    end
  end

  hart_mailbox #(.NCORES(NC), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .sel_packed_i   (sel_p),
    .we_packed_i    (we_p),
    .addr_packed_i  (addr_p),
    .wdata_packed_i (wdata_p),
    .rdata_packed_o (rdata_packed_o),
    .stall_packed_o (stall_packed_o)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rd(input int k);
    return rdata_packed_o[32*k +: 32];
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NC; k++) begin
      mq[k].delete();
      m_dest[k]   = 0;
      m_rr[k]     = 0;
      m_exp_rd[k] = '0;
    end
    exp_stall = '0;
  endtask

  // Evaluates one cycle from the pre-edge state, checks stalls, then commits.
  task automatic model_step();
    int win [NC];
    logic [NC-1:0] tx;
    int off, c, sz;
    for (int k = 0; k < NC; k++) begin
      win[k] = -1;
      off    = int'(addr[k][3:2]);
      tx[k]  = sel[k] && we[k] && off == 1 && m_dest[k] < NC;
    end
    for (int d = 0; d < NC; d++) begin
      if (mq[d].size() < DEPTH) begin
        for (int i = 0; i < NC; i++) begin
          c = (m_rr[d] + i) % NC;
          if (win[d] < 0 && tx[c] && m_dest[c] == d) win[d] = c;
        end
      end
    end
    for (int k = 0; k < NC; k++) begin
      exp_stall[k] = tx[k] && (win[m_dest[k]] != k);
      dut_st[k]    = stall_packed_o[k];
      check_eq($sformatf("stall[%0d]", k), 32'(stall_packed_o[k]), 32'(exp_stall[k]));
    end
    for (int k = 0; k < NC; k++) begin
      if (sel[k] && !we[k]) begin
        sz = mq[k].size();
        case (int'(addr[k][3:2]))
          0: m_exp_rd[k] = 32'(m_dest[k]);
          1: m_exp_rd[k] = '0;
          2: m_exp_rd[k] = (sz > 0) ? mq[k][0] : 32'h0;
          default: m_exp_rd[k] = {16'b0, 8'(sz), 6'b0, sz == DEPTH, sz == 0};
        endcase
        if (addr[k][3:2] == 2'd2 && sz > 0) void'(mq[k].pop_front());
      end
    end
    for (int d = 0; d < NC; d++) begin
      if (win[d] >= 0) begin
        mq[d].push_back(wdata[win[d]]);
        m_rr[d] = (win[d] + 1) % NC;
      end
    end
    for (int k = 0; k < NC; k++)
      if (sel[k] && we[k] && addr[k][3:2] == 2'd0) m_dest[k] = int'(wdata[k] % NC);
  endtask

  task automatic cycle();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
    for (int k = 0; k < NC; k++) begin
      check_eq($sformatf("rdata[%0d]", k), rd(k), m_exp_rd[k]);
      if (!exp_stall[k]) sel[k] = 1'b0;
    end
  endtask

  task automatic req(input int k, input logic w, input logic [1:0] off, input logic [31:0] d);
    sel[k]   = 1'b1;
    we[k]    = w;
    addr[k]  = {off, 2'b00};
    wdata[k] = d;
  endtask

  task automatic settle();
    int n;
    n = 0;
    while (sel[0] || sel[1] || sel[2] || sel[3]) begin
      if (n == 50) begin
        n_checks++;
        n_fail++;
        $display("FAIL settle_timeout: requests still pending after %0d cycles", n);
        for (int k = 0; k < NC; k++) sel[k] = 1'b0;
        break;
      end
      cycle();
      n++;
    end
  endtask

  initial begin
    rst_ni = 1'b0;
    for (int k = 0; k < NC; k++) begin
      sel[k] = 1'b0; we[k] = 1'b0; addr[k] = '0; wdata[k] = '0;
    end
    model_reset();
    #2;
    for (int k = 0; k < NC; k++) check_eq($sformatf("reset_rdata[%0d]", k), rd(k), 32'h0);
    check_eq("reset_stall", 32'(stall_packed_o), 32'h0);
    #10 rst_ni = 1'b1;

    // Three cores contend for hart 3 with a fresh round-robin pointer.
    for (int k = 0; k < 3; k++) req(k, 1'b1, 2'd0, 32'd3);
    settle();
    for (int k = 0; k < 3; k++) req(k, 1'b1, 2'd1, 32'hA0 + k);
    cycle(); check_eq("arb_c1", 32'(dut_st[2:0]), 32'b110);
    cycle(); check_eq("arb_c2", 32'(dut_st[2:0]), 32'b100);
    cycle(); check_eq("arb_c3", 32'(dut_st[2:0]), 32'b000);
    for (int k = 0; k < 3; k++) begin
      req(3, 1'b0, 2'd2, 0); settle();
      check_eq("arb_order", rd(3), 32'hA0 + k);
    end

    // Basic send/receive.
    req(0, 1'b1, 2'd0, 32'd2); settle();
    req(0, 1'b1, 2'd1, 32'hDEADBEEF); settle();
    req(2, 1'b0, 2'd3, 0); settle(); check_eq("t1_status", rd(2), 32'h100);
    req(2, 1'b0, 2'd2, 0); settle(); check_eq("t1_rx", rd(2), 32'hDEADBEEF);
    req(2, 1'b0, 2'd3, 0); settle(); check_eq("t1_status2", rd(2), 32'h1);

    // Full FIFO back-pressure.
    req(1, 1'b1, 2'd0, 32'd3); settle();
    for (int v = 1; v <= 4; v++) begin
      req(1, 1'b1, 2'd1, v); settle();
    end
    req(1, 1'b1, 2'd1, 32'd5);
    cycle(); check_eq("t2_full_stall", 32'(dut_st[1]), 32'h1);
    req(3, 1'b0, 2'd3, 0);
    cycle(); check_eq("t2_status", rd(3), 32'h402);
    req(3, 1'b0, 2'd2, 0);
    cycle(); check_eq("t2_pop1", rd(3), 32'h1);
    check_eq("t2_stall_on_pop", 32'(dut_st[1]), 32'h1);
    cycle(); check_eq("t2_release", 32'(dut_st[1]), 32'h0);
    for (int v = 2; v <= 5; v++) begin
      req(3, 1'b0, 2'd2, 0); settle();
      check_eq("t2_drain", rd(3), v);
    end

    // Empty RX, then push+pop on a FIFO with two entries.
    req(2, 1'b0, 2'd2, 0); cycle();
    check_eq("t4_rx_empty", rd(2), 32'h0);
    check_eq("t4_no_stall", 32'(dut_st[2]), 32'h0);
    req(2, 1'b0, 2'd3, 0); settle(); check_eq("t4_status", rd(2), 32'h1);
    req(0, 1'b1, 2'd0, 32'd2); settle();
    req(0, 1'b1, 2'd1, 32'h11); settle();
    req(0, 1'b1, 2'd1, 32'h22); settle();
    req(0, 1'b1, 2'd1, 32'h33); req(2, 1'b0, 2'd2, 0); settle();
    check_eq("t4_pushpop", rd(2), 32'h11);
    req(2, 1'b0, 2'd3, 0); settle(); check_eq("t4_count", rd(2), 32'h200);
    req(2, 1'b0, 2'd2, 0); settle(); check_eq("t4_order1", rd(2), 32'h22);
    req(2, 1'b0, 2'd2, 0); settle(); check_eq("t4_order2", rd(2), 32'h33);

    // Push and pop on an empty FIFO in the same cycle, then self-send.
    req(0, 1'b1, 2'd0, 32'd0); req(1, 1'b1, 2'd0, 32'd0); settle();
    req(1, 1'b1, 2'd1, 32'h12345678); req(0, 1'b0, 2'd2, 0); settle();
    check_eq("t5_same_cycle", rd(0), 32'h0);
    req(0, 1'b0, 2'd2, 0); settle(); check_eq("t5_next_rx", rd(0), 32'h12345678);
    req(0, 1'b1, 2'd1, 32'hCAFEF00D); settle();
    req(0, 1'b0, 2'd2, 0); settle(); check_eq("t5_self", rd(0), 32'hCAFEF00D);
    req(0, 1'b0, 2'd0, 0); settle(); check_eq("t5_dest", rd(0), 32'h0);

    // Random traffic; a stalled request is occasionally abandoned to avoid deadlock.
    for (int n = 0; n < 1500; n++) begin
      for (int k = 0; k < NC; k++) begin
        if (!sel[k]) begin
          if ($urandom_range(2) != 0)
            req(k, 1'($urandom_range(1)), 2'($urandom_range(3)), $urandom);
        end else if ($urandom_range(7) == 0) begin
          sel[k] = 1'b0;
        end
      end
      cycle();
    end
    for (int k = 0; k < NC; k++) sel[k] = 1'b0;
    cycle();

    // Reset while a push is stalled on a full FIFO.
    req(0, 1'b1, 2'd0, 32'd1); req(1, 1'b1, 2'd0, 32'd1); settle();
    for (int k = 0; k < NC; k++) begin
      req(1, 1'b0, 2'd2, 0); settle();
    end
    for (int v = 0; v < DEPTH; v++) begin
      req(0, 1'b1, 2'd1, 32'h50 + v); settle();
    end
    req(2, 1'b0, 2'd0, 0); settle();
    req(0, 1'b1, 2'd1, 32'h99);
    cycle(); check_eq("t6_pre_stall", 32'(dut_st[0]), 32'h1);
    rst_ni = 1'b0;
    #1;
    check_eq("t6_stall_drop", 32'(stall_packed_o), 32'h0);
    for (int k = 0; k < NC; k++) check_eq($sformatf("t6_rdata[%0d]", k), rd(k), 32'h0);
    for (int k = 0; k < NC; k++) sel[k] = 1'b0;
    model_reset();
    #2 rst_ni = 1'b1;
    req(1, 1'b0, 2'd3, 0); settle(); check_eq("t6_status", rd(1), 32'h1);
    req(0, 1'b0, 2'd0, 0); settle(); check_eq("t6_dest", rd(0), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
